// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver FSM states, bit-order and parity-mode constants.
// SERIAL_RX_PARITY_EN selects one trailing even-parity bit per word.
package serial_pkg;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } rx_state_e;

   localparam int unsigned BIT_ORDER_LSB_FIRST = 0;
   localparam int unsigned BIT_ORDER_MSB_FIRST = 1;

   // Matching serializer generates even parity over the data bits.
   localparam bit PARITY_EVEN = 1'b1;

`ifdef SERIAL_RX_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

endpackage

// File: rtl/serial_rx_out_buf.sv
// One-entry valid/ready holding register; flags overrun when a word arrives while full and not draining.
module serial_rx_out_buf #(
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   input  logic          ready_i,
   input  logic          clear_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          overrun_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          overrun_q, overrun_d;

   always_comb begin
      valid_d   = valid_q & ~ready_i;
      data_d    = data_q;
      overrun_d = overrun_q & ~clear_i;
      if (load_i) begin
         if (!valid_q || ready_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with buffered valid/ready output and sticky error flags.
// SERIAL_RX_PARITY_EN adds a trailing even-parity bit per word and the parity_err output.
module serial_word_receiver
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = BIT_ORDER_LSB_FIRST
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bit_valid,
   input  logic                       bit_in,
   input  logic                       frame_start,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       overrun,
   output logic                       frame_err,
   input  logic                       clear_flags
`ifdef SERIAL_RX_PARITY_EN
   ,
   output logic                       parity_err
`endif
);

   localparam int unsigned   CW        = $clog2(WIDTH + 1);
   localparam int unsigned   FRAME_LEN = WIDTH + PARITY_BITS;
   localparam int unsigned   BW        = WIDTH + PARITY_BITS;
   localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);

   rx_state_e        state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             frame_err_q, frame_err_d;
   logic             word_done;
   logic             data_bit;
   logic [BW-1:0]    buf_in, buf_out;

   always_comb begin
      if (MSB_FIRST == BIT_ORDER_MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], bit_in};
      else                                  shifted = {bit_in, shreg_q[WIDTH-1:1]};
   end

   // The parity bit completes the frame but never enters the data shift register.
`ifdef SERIAL_RX_PARITY_EN
   assign data_bit = (cnt_q != CW'(WIDTH));
   assign buf_in   = {(^shreg_q) ^ bit_in ^ ~PARITY_EVEN, shreg_q};
`else
   assign data_bit = 1'b1;
   assign buf_in   = shifted;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = frame_err_q & ~clear_flags;
      word_done   = 1'b0;
      if (frame_start) begin
         if (cnt_q != '0) frame_err_d = 1'b1;
         if (bit_valid) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
            state_d = RX_RECV;
         end else begin
            cnt_d   = '0;
            state_d = RX_IDLE;
         end
      end else if (bit_valid) begin
         if (data_bit) shreg_d = shifted;
         if (cnt_q == LAST_CNT) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = RX_IDLE;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = RX_RECV;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
      end
   end

   serial_rx_out_buf #(
      .DW(BW)
   ) u_out_buf (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .load_i   (word_done),
      .data_i   (buf_in),
      .ready_i  (out_ready),
      .clear_i  (clear_flags),
      .valid_o  (out_valid),
      .data_o   (buf_out),
      .overrun_o(overrun)
   );

   assign out_data  = buf_out[WIDTH-1:0];
`ifdef SERIAL_RX_PARITY_EN
   assign parity_err = buf_out[WIDTH];
`endif
   assign busy      = (state_q == RX_RECV);
   assign bit_cnt   = cnt_q;
   assign frame_err = frame_err_q;

endmodule
